pipe_io_port: RTL and testbench

Memory-mapped I/O unit for the pipelined computer. It sits beside data memory in the MEM stage and decodes loads and stores to the I/O window. It feeds the board switches `SW9..SW0` into the datapath as operands, and drives `HEX5..HEX0` with the program's results as two-digit decimal numbers. The unit contains:
- a switch synchronizer/debouncer;
- three output registers;
- one sequential binary-to-decimal converter shared by the three displays.

---
 rtl/pipe_io_port_pkg.sv | 38 +++
 rtl/io_debounce.sv | 39 +++
 rtl/pipe_io_port.sv | 146 ++++++++++++++
 tb/tb_pipe_io_port.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_io_port_pkg.sv
// Shared constants for the pipelined computer's memory-mapped I/O port:
// register addresses, window select bit, seven-segment patterns and converter states.
package pipe_io_port_pkg;

   localparam int WINDOW_BIT = 7;

   localparam logic [7:0] ADDR_SW_LO = 8'h80;
   localparam logic [7:0] ADDR_SW_HI = 8'h84;
   localparam logic [7:0] ADDR_OUT0  = 8'h88;
   localparam logic [7:0] ADDR_OUT1  = 8'h8C;
   localparam logic [7:0] ADDR_OUT2  = 8'h90;

   localparam logic [4:0] WORD_SW_LO = ADDR_SW_LO[6:2];
   localparam logic [4:0] WORD_SW_HI = ADDR_SW_HI[6:2];
   localparam logic [4:0] WORD_OUT0  = ADDR_OUT0[6:2];
   localparam logic [4:0] WORD_OUT1  = ADDR_OUT1[6:2];
   localparam logic [4:0] WORD_OUT2  = ADDR_OUT2[6:2];

   // Active-low gfedcba, entry 9 first.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_DIV   = 2'd1,
      ST_STORE = 2'd2
   } conv_state_t;

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      if (digit > 4'd9) seg = 7'b1111111;
      else              seg = SEG_TABLE[digit];
      return seg;
   endfunction

endpackage

// File: rtl/io_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability counter that
// accepts a new level only after it has differed from the accepted one long enough.
module io_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic sw_raw,
   output logic swd
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES);

   logic          sync_a;
   logic          s;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_a <= 1'b0;
         s      <= 1'b0;
         cnt    <= '0;
         swd    <= 1'b0;
      end else begin
         sync_a <= sw_raw;
         s      <= sync_a;
         if (s == swd) begin
            cnt <= '0;
         end else if (cnt == CNT_TC) begin
            swd <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pipe_io_port.sv
// MEM-stage I/O window: debounced switches in, three display registers out,
// one round-robin binary-to-decimal converter feeding the six HEX digits.
//
// state | meaning
// LOAD  | capture saturated out[ch] into v, clear tens
// DIV   | subtract 10 per cycle while v >= 10
// STORE | latch tens/ones into channel ch digits, advance ch
import pipe_io_port_pkg::*;

module pipe_io_port #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   output logic [31:0] rdata,
   input  logic [9:0]  sw,
   output logic [6:0]  hex5,
   output logic [6:0]  hex4,
   output logic [6:0]  hex3,
   output logic [6:0]  hex2,
   output logic [6:0]  hex1,
   output logic [6:0]  hex0
);

   logic [9:0]       swd;
   logic [31:0]      out0, out1, out2;
   logic             in_window;
   logic [4:0]       word;
   logic             unused_addr;

   conv_state_t      state, state_nxt;
   logic [1:0]       ch, ch_nxt;
   logic [6:0]       v, v_nxt;
   logic [3:0]       tens, tens_nxt;
   logic [31:0]      cur_out;
   logic [2:0][3:0]  dig_tens, dig_ones;

   assign in_window   = addr[WINDOW_BIT];
   assign word        = addr[6:2];
   assign unused_addr = ^{addr[31:8], addr[1:0]};

   for (genvar i = 0; i < 10; i++) begin : g_db
      io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clock  (clock),
         .reset  (reset),
         .sw_raw (sw[i]),
         .swd    (swd[i])
      );
   end

   always_comb begin
      rdata = '0;
      if (in_window) begin
         case (word)
            WORD_SW_LO: rdata = {27'b0, swd[4:0]};
            WORD_SW_HI: rdata = {27'b0, swd[9:5]};
            WORD_OUT0:  rdata = out0;
            WORD_OUT1:  rdata = out1;
            WORD_OUT2:  rdata = out2;
            default:    rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out0 <= '0;
         out1 <= '0;
         out2 <= '0;
      end else if (we && in_window) begin
         case (word)
            WORD_OUT0: out0 <= wdata;
            WORD_OUT1: out1 <= wdata;
            WORD_OUT2: out2 <= wdata;
            default:   ;
         endcase
      end
   end

   always_comb begin
      case (ch)
         2'd1:    cur_out = out1;
         2'd2:    cur_out = out2;
         default: cur_out = out0;
      endcase
      state_nxt = state;
      ch_nxt    = ch;
      v_nxt     = v;
      tens_nxt  = tens;
      case (state)
         ST_LOAD: begin
            // Anything above 99 shows as 99 on a two-digit display.
            v_nxt     = (|cur_out[31:7] || cur_out[6:0] > 7'd99) ? 7'd99 : cur_out[6:0];
            tens_nxt  = '0;
            state_nxt = ST_DIV;
         end
         ST_DIV: begin
            if (v >= 7'd10) begin
               v_nxt    = v - 7'd10;
               tens_nxt = tens + 4'd1;
            end else begin
               state_nxt = ST_STORE;
            end
         end
         ST_STORE: begin
            ch_nxt    = (ch == 2'd2) ? 2'd0 : ch + 2'd1;
            state_nxt = ST_LOAD;
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_LOAD;
         ch       <= '0;
         v        <= '0;
         tens     <= '0;
         dig_tens <= '0;
         dig_ones <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
         v     <= v_nxt;
         tens  <= tens_nxt;
         if (state == ST_STORE) begin
            case (ch)
               2'd1:    begin dig_tens[1] <= tens; dig_ones[1] <= v[3:0]; end
               2'd2:    begin dig_tens[2] <= tens; dig_ones[2] <= v[3:0]; end
               default: begin dig_tens[0] <= tens; dig_ones[0] <= v[3:0]; end
            endcase
         end
      end
   end

   assign hex0 = seg_decode(dig_ones[0]);
   assign hex1 = seg_decode(dig_tens[0]);
   assign hex2 = seg_decode(dig_ones[1]);
   assign hex3 = seg_decode(dig_tens[1]);
   assign hex4 = seg_decode(dig_ones[2]);
   assign hex5 = seg_decode(dig_tens[2]);

endmodule

// File: tb/tb_pipe_io_port.sv
// Bench for pipe_io_port: directed scenarios plus random bus/switch traffic,
// checked every cycle against a behavioural model of the register map, debounce and display scan.
module tb_pipe_io_port;

  localparam int DB = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we;
  logic [9:0]  sw;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;

  pipe_io_port #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata),
    .sw(sw), .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
  );

  always #5 clock = ~clock;

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG9 = 7'b0010000;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [31:0] m_out [3];
  bit   [9:0]  m_swd, m_s1, m_s2;
  int          m_run [10];
  int          m_ch, m_left, m_snap;
  bit          m_busy;
  int          m_dig [3];

  function automatic int sat99(input logic [31:0] x);
    return (x > 32'd99) ? 99 : int'(x);
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a[7]) begin
      case (a[6:2])
        5'd0: r = {27'd0, m_swd[4:0]};
        5'd1: r = {27'd0, m_swd[9:5]};
        5'd2: r = m_out[0];
        5'd3: r = m_out[1];
        5'd4: r = m_out[2];
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_out[i] = 0; m_dig[i] = 0; end
      for (int i = 0; i < 10; i++) m_run[i] = 0;
      m_swd = 0; m_s1 = 0; m_s2 = 0;
      m_ch = 0; m_busy = 0; m_left = 0; m_snap = 0;
    end else begin
      // A visit is LOAD + (tens+1) DIV + STORE; digits land on the last edge.
      if (!m_busy) begin
        m_snap = sat99(m_out[m_ch]);
        m_left = m_snap / 10 + 2;
        m_busy = 1;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_dig[m_ch] = m_snap;
          m_ch = (m_ch + 1) % 3;
          m_busy = 0;
        end
      end
      // swd takes the synchronized level once it has differed for DB+1 sampled cycles.
      for (int i = 0; i < 10; i++) begin
        if (m_s2[i] != m_swd[i]) begin
          if (m_run[i] == DB) begin m_swd[i] = m_s2[i]; m_run[i] = 0; end
          else m_run[i]++;
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = sw;
      if (we && addr[7]) begin
        case (addr[6:2])
          5'd2: m_out[0] = wdata;
          5'd3: m_out[1] = wdata;
          5'd4: m_out[2] = wdata;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      chk("rdata", rdata, exp_rdata(addr));
      chk("hex1:hex0", {hex1, hex0}, {seg_ref[m_dig[0] / 10], seg_ref[m_dig[0] % 10]});
      chk("hex3:hex2", {hex3, hex2}, {seg_ref[m_dig[1] / 10], seg_ref[m_dig[1] % 10]});
      chk("hex5:hex4", {hex5, hex4}, {seg_ref[m_dig[2] / 10], seg_ref[m_dig[2] % 10]});
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_pair(input string name, input int pair, input logic [13:0] want);
    logic [13:0] got;
    got = 14'd0;
    for (int i = 0; i < 60; i++) begin
      got = (pair == 0) ? {hex1, hex0} : (pair == 1) ? {hex3, hex2} : {hex5, hex4};
      if (got == want) break;
      tick();
    end
    chk(name, {18'd0, got}, {18'd0, want});
  endtask

  task automatic wait_model(input int ch, input int snap, input int min_left);
    bit ok;
    ok = 0;
    for (int i = 0; i < 120 && !ok; i++) begin
      if (m_busy && m_ch == ch && m_snap == snap && m_left > min_left) ok = 1;
      else tick();
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL wait_visit: channel %0d never converted %0d", ch, snap);
    end
  endtask

  initial begin
    logic [31:0] r, a;
    logic [7:0]  sel [8];
    sel = '{8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h94, 8'hFC, 8'h08};

    reset = 1'b1; addr = 0; wdata = 0; we = 0; sw = 0;
    repeat (3) tick();
    reset = 1'b0;
    checking = 1;

    chk("reset_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{SEG0}});
    addr = 32'h88; #1 chk("reset_out0", rdata, 32'd0);
    addr = 32'h80; #1 chk("reset_sw_lo", rdata, 32'd0);

    // Display after write, with read-after-write on the next cycle
    write(32'h88, 32'h2A);
    addr = 32'h88; #1 chk("raw_out0", rdata, 32'h2A);
    wait_pair("disp_42", 0, {SEG4, SEG2});
    chk("disp_others", {hex5, hex4, hex3, hex2}, {4{SEG0}});

    // Saturation; upper address bits and byte offset are ignored
    write(32'hABCD_1291, 32'd500);
    addr = 32'h90; #1 chk("raw_out2", rdata, 32'h1F4);
    wait_pair("disp_sat", 2, {SEG9, SEG9});
    addr = 32'h10; #1 chk("dmem_zero", rdata, 32'd0);
    write(32'h84, 32'hFFFF);
    addr = 32'h84; #1 chk("ro_write", rdata, 32'd0);

    // Switch acceptance: first sampling edge plus DB+2 edges
    sw = 10'h108;
    for (int k = 1; k <= DB + 2; k++) begin
      tick();
      addr = 32'h80; #1 chk("sw_lo_early", rdata, 32'd0);
      addr = 32'h84; #1 chk("sw_hi_early", rdata, 32'd0);
    end
    tick();
    addr = 32'h80; #1 chk("sw_lo_accept", rdata, 32'h08);
    addr = 32'h84; #1 chk("sw_hi_accept", rdata, 32'h08);

    // Glitch rejection
    addr = 32'h80;
    sw[0] = 1'b1;
    repeat (10) begin tick(); chk("glitch_bit0", {31'd0, rdata[0]}, 32'd0); end
    sw[0] = 1'b0;
    repeat (30) begin tick(); chk("glitch_bit0", {31'd0, rdata[0]}, 32'd0); end

    // Mid-conversion write: snapshot 99 is shown, then the later 7
    write(32'h8C, 32'd99);
    wait_model(1, 99, 3);
    write(32'h8C, 32'd7);
    wait_pair("disp_99_first", 1, {SEG9, SEG9});
    wait_pair("disp_07_next", 1, {SEG0, SEG7});

    // Reset in the middle of a long DIV phase
    write(32'h88, 32'd95);
    wait_model(0, 95, 4);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mid_hex", {hex5, hex4, hex3, hex2, hex1, hex0}, {6{SEG0}});
    addr = 32'h8C; #1 chk("rst_mid_out1", rdata, 32'd0);

    // Random traffic checked by the per-cycle compare
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      a = $urandom;
      addr = {a[31:8], sel[r[2:0]][7:2], a[1:0]};
      we = (r[5:4] == 2'b00);
      case (r[7:6])
        2'b00, 2'b01: wdata = $urandom_range(0, 99);
        2'b10:        wdata = $urandom_range(0, 255);
        default:      wdata = $urandom;
      endcase
      if (r[15:10] == 6'd0) sw = 10'($urandom);
      else if (r[15:10] == 6'd1) sw[r[19:16] % 10] = ~sw[r[19:16] % 10];
      reset = (r[27:20] == 8'd0);
      tick();
    end
    reset = 1'b0; we = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
